// File: rtl/racha_cero_pkg.sv
`default_nettype none
// racha_cero_pkg: state encoding and default widths shared by the zero-run detector.
// Revision 1.0
package racha_cero_pkg;

  localparam int ANCHO_DEF     = 16;
  localparam int ANCHO_CNT_DEF = 8;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    RACHA  = 2'd1,
    EMITE  = 2'd2
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/racha_cero_igual_cero.sv
`default_nettype none
// igual_cero: flags a tuple whose bits are all zero.
// Revision 1.0
module igual_cero
  import racha_cero_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  output logic             flag,
  input  logic [ANCHO-1:0] tupla
);

  assign flag = ~|tupla;

endmodule
`default_nettype wire

// File: rtl/racha_cero.sv
`default_nettype none
// racha_cero: measures runs of all-zero tuples and reports each completed run downstream.
// Revision 1.0
module racha_cero
  import racha_cero_pkg::*;
#(
  parameter int ANCHO     = ANCHO_DEF,
  parameter int ANCHO_CNT = ANCHO_CNT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tupla_valid,
  input  logic [ANCHO-1:0]     tupla,
  output logic                 tupla_ready,
  output logic                 evento_valid,
  output logic [ANCHO_CNT-1:0] evento_largo,
  input  logic                 evento_ready,
  output logic [ANCHO_CNT-1:0] total_ceros,
  output logic [ANCHO_CNT-1:0] racha_max
);

  localparam logic [ANCHO_CNT-1:0] CNT_MAX = '1;
  localparam logic [ANCHO_CNT-1:0] CNT_UNO = ANCHO_CNT'(1);

  estado_t              estado;
  logic [ANCHO_CNT-1:0] racha;
  logic                 es_cero;
  logic                 acepta;

  igual_cero #(
    .ANCHO(ANCHO)
  ) u_igual_cero (
    .flag (es_cero),
    .tupla(tupla)
  );

  // Handshake flags depend on the registered state only.
  assign tupla_ready  = (estado != EMITE);
  assign evento_valid = (estado == EMITE);
  assign acepta       = tupla_valid && tupla_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado       <= REPOSO;
      racha        <= '0;
      evento_largo <= '0;
      total_ceros  <= '0;
      racha_max    <= '0;
    end else begin
      if (acepta && es_cero && (total_ceros != CNT_MAX)) begin
        total_ceros <= total_ceros + CNT_UNO;
      end

      unique case (estado)
        REPOSO: begin
          if (acepta && es_cero) begin
            racha  <= CNT_UNO;
            estado <= RACHA;
          end
        end
        RACHA: begin
          if (acepta) begin
            if (es_cero) begin
              if (racha != CNT_MAX) begin
                racha <= racha + CNT_UNO;
              end
            end else begin
              // Terminating tuple is consumed here; the run is frozen into the report.
              evento_largo <= racha;
              if (racha > racha_max) begin
                racha_max <= racha;
              end
              estado <= EMITE;
            end
          end
        end
        EMITE: begin
          if (evento_ready) begin
            racha  <= '0;
            estado <= REPOSO;
          end
        end
        default: begin
          racha  <= '0;
          estado <= REPOSO;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_racha_cero.sv
`default_nettype none
// tb_racha_cero: randomized and directed checks of racha_cero against a run-length reference model.
// Revision 1.0
module tb_racha_cero;

  localparam int W  = 16;
  localparam int C  = 8;
  localparam int C2 = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tupla_valid;
  logic [W-1:0]  tupla;
  logic          evento_ready;

  logic          a_ready, a_valid;
  logic [C-1:0]  a_largo, a_total, a_max;
  logic          b_ready, b_valid;
  logic [C2-1:0] b_largo, b_total, b_max;

  racha_cero #(.ANCHO(W), .ANCHO_CNT(C)) dut_a (
    .clk(clk), .reset(reset), .tupla_valid(tupla_valid), .tupla(tupla),
    .tupla_ready(a_ready), .evento_valid(a_valid), .evento_largo(a_largo),
    .evento_ready(evento_ready), .total_ceros(a_total), .racha_max(a_max)
  );

  racha_cero #(.ANCHO(W), .ANCHO_CNT(C2)) dut_b (
    .clk(clk), .reset(reset), .tupla_valid(tupla_valid), .tupla(tupla),
    .tupla_ready(b_ready), .evento_valid(b_valid), .evento_largo(b_largo),
    .evento_ready(evento_ready), .total_ceros(b_total), .racha_max(b_max)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: unsaturated run/total/max, saturation applied when compared.
  int m_run, m_total, m_max, m_rep, m_taken, obs_taken;
  bit m_pend;

  function automatic int sat(input int v, input int bits);
    int cap;
    cap = (1 << bits) - 1;
    return (v > cap) ? cap : v;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] t, input logic r);
    tupla_valid  = v;
    tupla        = t;
    evento_ready = r;
    if (a_valid && r) obs_taken++;
    @(posedge clk);
    if (m_pend) begin
      if (r) begin
        m_pend = 1'b0;
        m_taken++;
      end
    end else if (v) begin
      if (t == '0) begin
        m_run++;
        m_total++;
      end else if (m_run > 0) begin
        m_rep  = m_run;
        if (m_run > m_max) m_max = m_run;
        m_pend = 1'b1;
        m_run  = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    tupla_valid  = 1'b0;
    tupla        = '0;
    evento_ready = 1'b0;
    reset        = 1'b1;
    m_run = 0; m_total = 0; m_max = 0; m_rep = 0; m_taken = 0; obs_taken = 0;
    m_pend = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tupla_valid = 1'b0; tupla = '0; evento_ready = 1'b0;
    #2;
    tests++;
    if ({a_ready, a_valid, a_largo, a_total, a_max} !== {1'b1, 1'b0, 24'd0}) begin
      fails++;
      $display("FAIL reset_a: got rdy=%0b vld=%0b largo=%0d tot=%0d max=%0d want 1 0 0 0 0",
               a_ready, a_valid, a_largo, a_total, a_max);
    end
    tests++;
    if ({b_ready, b_valid, b_largo, b_total, b_max} !== {1'b1, 1'b0, 6'd0}) begin
      fails++;
      $display("FAIL reset_b: got rdy=%0b vld=%0b largo=%0d tot=%0d max=%0d want 1 0 0 0 0",
               b_ready, b_valid, b_largo, b_total, b_max);
    end
    do_reset();
  endtask

  task automatic test_single_run();
    do_reset();
    step(1'b1, 16'd0, 1'b1);
    for (int k = 1; k <= 7; k++) step(1'b1, W'(k), 1'b1);
    tests++;
    if (obs_taken !== 1) begin
      fails++; $display("FAIL single_reports: got %0d want 1", obs_taken);
    end
    tests++;
    if ({a_largo, a_total, a_max} !== {8'd1, 8'd1, 8'd1}) begin
      fails++; $display("FAIL single_vals: got largo=%0d tot=%0d max=%0d want 1 1 1", a_largo, a_total, a_max);
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(1'b1, 16'd0, 1'b0); step(1'b1, 16'd0, 1'b0); step(1'b1, 16'd0, 1'b0);
    step(1'b1, 16'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({a_valid, a_ready, a_largo} !== {1'b1, 1'b0, 8'd3}) begin
        fails++; $display("FAIL hold_%0d: got vld=%0b rdy=%0b largo=%0d want 1 0 3", k, a_valid, a_ready, a_largo);
      end
      step(1'b0, 16'd0, 1'b0);
    end
    step(1'b0, 16'd0, 1'b1);
    tests++;
    if ({a_valid, a_ready, a_largo} !== {1'b0, 1'b1, 8'd3}) begin
      fails++; $display("FAIL hold_take: got vld=%0b rdy=%0b largo=%0d want 0 1 3", a_valid, a_ready, a_largo);
    end
  endtask

  task automatic test_two_runs();
    do_reset();
    step(1'b1, 16'd0, 1'b1); step(1'b1, 16'd0, 1'b1); step(1'b1, 16'd5, 1'b1);
    tests++;
    if ({a_valid, a_largo} !== {1'b1, 8'd2}) begin
      fails++; $display("FAIL two_first: got vld=%0b largo=%0d want 1 2", a_valid, a_largo);
    end
    step(1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 16'd0, 1'b1);
    step(1'b1, 16'd9, 1'b1);
    tests++;
    if ({a_valid, a_largo} !== {1'b1, 8'd4}) begin
      fails++; $display("FAIL two_second: got vld=%0b largo=%0d want 1 4", a_valid, a_largo);
    end
    step(1'b0, 16'd0, 1'b1);
    tests++;
    if ({a_max, a_total, 8'(obs_taken)} !== {8'd4, 8'd6, 8'd2}) begin
      fails++; $display("FAIL two_totals: got max=%0d tot=%0d reports=%0d want 4 6 2", a_max, a_total, obs_taken);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 16'd0, 1'b0);
    step(1'b1, 16'd1, 1'b0);
    tests++;
    if ({b_valid, b_largo, b_total, b_max} !== {1'b1, 2'd3, 2'd3, 2'd3}) begin
      fails++; $display("FAIL sat_small: got vld=%0b largo=%0d tot=%0d max=%0d want 1 3 3 3", b_valid, b_largo, b_total, b_max);
    end
    tests++;
    if (a_largo !== 8'd6) begin
      fails++; $display("FAIL sat_wide: got largo=%0d want 6", a_largo);
    end
    step(1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 300; k++) step(1'b1, 16'd0, 1'b1);
    step(1'b1, 16'hffff, 1'b1);
    tests++;
    if ({a_valid, a_largo, a_total, a_max} !== {1'b1, 8'd255, 8'd255, 8'd255}) begin
      fails++; $display("FAIL sat_long: got vld=%0b largo=%0d tot=%0d max=%0d want 1 255 255 255", a_valid, a_largo, a_total, a_max);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 16'd0, 1'b1);
    do_reset();
    step(1'b1, 16'd7, 1'b1);
    tests++;
    if ({a_valid, a_ready, a_largo, a_total, a_max} !== {1'b0, 1'b1, 24'd0}) begin
      fails++; $display("FAIL reset_mid: got vld=%0b rdy=%0b largo=%0d tot=%0d max=%0d want 0 1 0 0 0",
                        a_valid, a_ready, a_largo, a_total, a_max);
    end
    step(1'b1, 16'd0, 1'b0); step(1'b1, 16'd3, 1'b0);
    do_reset();
    step(1'b0, 16'd0, 1'b1);
    tests++;
    if ({a_valid, a_largo, a_max} !== {1'b0, 16'd0}) begin
      fails++; $display("FAIL reset_pending: got vld=%0b largo=%0d max=%0d want 0 0 0", a_valid, a_largo, a_max);
    end
  endtask

  task automatic test_valid_gaps();
    do_reset();
    step(1'b1, 16'd0, 1'b0);
    step(1'b0, W'($urandom_range(1, 65535)), 1'b0);
    step(1'b1, 16'd0, 1'b0);
    step(1'b0, W'($urandom_range(1, 65535)), 1'b0);
    step(1'b1, 16'd3, 1'b0);
    tests++;
    if ({a_valid, a_largo, a_total} !== {1'b1, 8'd2, 8'd2}) begin
      fails++; $display("FAIL gaps: got vld=%0b largo=%0d tot=%0d want 1 2 2", a_valid, a_largo, a_total);
    end
  endtask

  task automatic test_random();
    logic          v, r;
    logic [W-1:0]  t;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      t = ($urandom_range(0, 9) < 6) ? '0 : W'(1 << $urandom_range(0, W - 1));
      step(v, t, r);
      tests++;
      if ({a_valid, a_ready, b_valid, b_ready} !== {m_pend, !m_pend, m_pend, !m_pend}) begin
        fails++; $display("FAIL rnd_hs@%0d: got a=%0b%0b b=%0b%0b want vld=%0b", n, a_valid, a_ready, b_valid, b_ready, m_pend);
      end
      tests++;
      if ({a_largo, a_total, a_max} !== {8'(sat(m_rep, C)), 8'(sat(m_total, C)), 8'(sat(m_max, C))}) begin
        fails++; $display("FAIL rnd_a@%0d: got largo=%0d tot=%0d max=%0d want %0d %0d %0d", n,
                          a_largo, a_total, a_max, sat(m_rep, C), sat(m_total, C), sat(m_max, C));
      end
      tests++;
      if ({b_largo, b_total, b_max} !== {2'(sat(m_rep, C2)), 2'(sat(m_total, C2)), 2'(sat(m_max, C2))}) begin
        fails++; $display("FAIL rnd_b@%0d: got largo=%0d tot=%0d max=%0d want %0d %0d %0d", n,
                          b_largo, b_total, b_max, sat(m_rep, C2), sat(m_total, C2), sat(m_max, C2));
      end
    end
    tests++;
    if (obs_taken !== m_taken) begin
      fails++; $display("FAIL rnd_reports: got %0d want %0d", obs_taken, m_taken);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_hold();
    test_two_runs();
    test_saturate();
    test_reset_mid();
    test_valid_gaps();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
